// File: rtl/cpu_addr_pkg.sv
// Shared address-map constants for the fetch unit, NPC logic and memory paths.
package cpu_addr_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;
    localparam int          IM_IDX_W     = $clog2(IM_WORDS_DEF);

    // Exclusive upper byte bound of a word-addressed region, widened so base+size cannot wrap.
    function automatic logic [32:0] region_limit(input logic [31:0] base, input int words);
        return {1'b0, base} + (33'(words) << 2);
    endfunction

endpackage

// File: rtl/pc_range_check.sv
// Alignment and window check for a word address; shared by fetch and data-memory paths.
module pc_range_check
    import cpu_addr_pkg::*;
#(
    parameter logic [31:0] BASE  = IM_BASE_DEF,
    parameter int          WORDS = IM_WORDS_DEF
) (
    input  logic [31:0] addr,
    output logic        fault
);

    localparam logic [32:0] LIMIT = region_limit(BASE, WORDS);

    logic misaligned;
    logic below;
    logic above;

    always_comb begin
        misaligned = (addr[1:0] != 2'b00);
        below      = (addr < BASE);
        above      = ({1'b0, addr} >= LIMIT);
        fault      = misaligned | below | above;
    end

endmodule

// File: rtl/pc_reg.sv
// Program counter register with derived fetch address, increment and fault flag.
module pc_reg
    import cpu_addr_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF,
    localparam int         IDX_W    = $clog2(IM_WORDS)
) (
    input  logic             clk,
    input  logic             res,
    input  logic [31:0]      pc,
    input  logic             WE,
    output logic [31:0]      PC,
    output logic [31:0]      pc_plus4,
    output logic [IDX_W-1:0] im_addr,
    output logic             addr_fault
);

    logic [31:0] im_offset;

    // Values are stored as given; bad addresses surface through addr_fault, not correction.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            PC <= RESET_PC;
        end else if (WE) begin
            PC <= pc;
        end
    end

    always_comb begin
        pc_plus4  = PC + 32'd4;
        im_offset = PC - IM_BASE;
        im_addr   = im_offset[IDX_W+1:2];
    end

    pc_range_check #(
        .BASE  (IM_BASE),
        .WORDS (IM_WORDS)
    ) u_range_check (
        .addr  (PC),
        .fault (addr_fault)
    );

endmodule

// File: tb/tb_pc_reg.sv
// Directed-vector bench for pc_reg with default address map.
module tb_pc_reg;

    logic        clk;
    logic        res;
    logic [31:0] pc;
    logic        WE;
    logic [31:0] PC;
    logic [31:0] pc_plus4;
    logic [11:0] im_addr;
    logic        addr_fault;

    int n_cmp;
    int n_bad;

    pc_reg dut (
        .clk        (clk),
        .res        (res),
        .pc         (pc),
        .WE         (WE),
        .PC         (PC),
        .pc_plus4   (pc_plus4),
        .im_addr    (im_addr),
        .addr_fault (addr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] v);
        @(negedge clk);
        pc = v;
        WE = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        res = 1'b0;
        WE  = 1'b0;
        pc  = 32'h0;
        #12;
        chk("rst_pc",    PC, 32'h0000_3000);
        chk("rst_plus4", pc_plus4, 32'h0000_3004);
        chk("rst_im",    32'(im_addr), 32'd0);
        chk("rst_fault", 32'(addr_fault), 32'd0);

        @(negedge clk);
        res = 1'b1;
        pc  = 32'h0000_3004;
        WE  = 1'b1;
        @(posedge clk); #1;
        chk("ld1_pc",    PC, 32'h0000_3004);
        chk("ld1_im",    32'(im_addr), 32'd1);
        chk("ld1_plus4", pc_plus4, 32'h0000_3008);
        pc = 32'h0000_3008;
        @(posedge clk); #1;
        chk("ld2_pc",    PC, 32'h0000_3008);
        chk("ld2_im",    32'(im_addr), 32'd2);
        chk("ld2_plus4", pc_plus4, 32'h0000_300C);

        WE = 1'b0;
        pc = 32'h0000_4000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_pc", PC, 32'h0000_3008);
        end

        load(32'h0000_3002);
        chk("misalign_fault", 32'(addr_fault), 32'd1);
        chk("misalign_pc",    PC, 32'h0000_3002);
        load(32'h0000_2FFC);
        chk("below_fault", 32'(addr_fault), 32'd1);
        load(32'h0000_7000);
        chk("limit_fault", 32'(addr_fault), 32'd1);
        load(32'h0000_6FFC);
        chk("top_fault", 32'(addr_fault), 32'd0);
        chk("top_im",    32'(im_addr), 32'd4095);
        load(32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        chk("wrap_fault", 32'(addr_fault), 32'd1);

        load(32'h0000_3010);
        chk("pre_rst_pc", PC, 32'h0000_3010);
        #3;
        WE  = 1'b1;
        pc  = 32'h0000_5000;
        res = 1'b0;
        #1;
        chk("async_pc",    PC, 32'h0000_3000);
        chk("async_im",    32'(im_addr), 32'd0);
        chk("async_fault", 32'(addr_fault), 32'd0);
        @(posedge clk); #1;
        chk("rst_we_pc", PC, 32'h0000_3000);
        @(posedge clk); #1;
        chk("rst_we_pc2", PC, 32'h0000_3000);

        @(negedge clk);
        WE  = 1'b0;
        res = 1'b1;
        @(posedge clk); #1;
        chk("release_hold", PC, 32'h0000_3000);
        load(32'h0000_3020);
        chk("release_ld", PC, 32'h0000_3020);
        chk("release_im", 32'(im_addr), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
